// File: rtl/resource_arbiter.sv
// resource_arbiter: shares one downstream resource among four requesters.
// Grants are held until the owner drops its request or the hold watchdog
// (TIMEOUT_CYCLES, 0 = off) preempts it. Fixed priority, highest index wins.
// Optional macro ARB_ROUND_ROBIN_EN switches to rotating priority where the
// last granted index becomes the lowest priority for the next arbitration.
// All outputs are registered; req never reaches gnt combinationally.
module resource_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout_pulse
);

  // Hold counter width; kept at least one bit so the watchdog-off build elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       cand;
  logic [1:0]       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  // Search last-1, last-2, ... wrapping, so the last owner is tried last.
  function automatic logic [1:0] pick_rr(input logic [3:0] c, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] probe;
    logic       found;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      probe = last - 2'(i);
      if (!found && c[probe]) begin
        idx   = probe;
        found = 1'b1;
      end
    end
    return idx;
  endfunction
`else
  // Highest set index wins.
  function automatic logic [1:0] pick_fixed(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) idx = 2'(i);
    end
    return idx;
  endfunction
`endif

  // Counter advance that sticks at the watchdog limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Candidate selection for the next arbitration.
  always_comb begin
    cand = req & ~mask_q;
`ifdef ARB_ROUND_ROBIN_EN
    win  = pick_rr(cand, rr_ptr_q);
`else
    win  = pick_fixed(cand);
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    gnt_valid_d     = gnt_valid_q;
    timeout_pulse_d = 1'b0;
    cnt_d           = cnt_q;
    mask_d          = mask_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d        = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cand != 4'b0000) begin
          gnt_d       = 4'b0001 << win;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          mask_d      = 4'b0000;
          state_d     = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d    = win;
`endif
        end else if (req != 4'b0000) begin
          // Only the just-preempted requester is asking: let it back in next cycle.
          mask_d = 4'b0000;
        end
      end
      BUSY: begin
        if (!req[gnt_id_q]) begin
          // A release takes precedence over a coincident timeout.
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          mask_d      = 4'b0000;
          state_d     = IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          gnt_d           = 4'b0000;
          gnt_valid_d     = 1'b0;
          timeout_pulse_d = 1'b1;
          mask_d          = gnt_q;
          state_d         = IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gnt_q           <= 4'b0000;
      gnt_id_q        <= 2'd0;
      gnt_valid_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      cnt_q           <= '0;
      mask_q          <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q        <= 2'd3;
`endif
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_id_q        <= gnt_id_d;
      gnt_valid_q     <= gnt_valid_d;
      timeout_pulse_q <= timeout_pulse_d;
      cnt_q           <= cnt_d;
      mask_q          <= mask_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q        <= rr_ptr_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign gnt_id        = gnt_id_q;
  assign gnt_valid     = gnt_valid_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter (TIMEOUT_CYCLES=16). Expected outputs
// are queued when a step is driven and checked after the following edge.
module tb_resource_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout_pulse;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       p;
  } exp_t;

  exp_t  sb[$];
  string tags[$];

  resource_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [3:0] g, input logic [1:0] id,
                      input logic v, input logic p);
    exp_t e;
    e.g  = g;
    e.id = id;
    e.v  = v;
    e.p  = p;
    sb.push_back(e);
    tags.push_back(t);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    t = tags.pop_front();
    vectors++;
    assert (gnt === e.g) else begin
      miscompares++;
      $error("FAIL %s gnt: observed %b expected %b", t, gnt, e.g);
    end
    vectors++;
    assert (gnt_valid === e.v) else begin
      miscompares++;
      $error("FAIL %s gnt_valid: observed %b expected %b", t, gnt_valid, e.v);
    end
    vectors++;
    assert (timeout_pulse === e.p) else begin
      miscompares++;
      $error("FAIL %s timeout_pulse: observed %b expected %b", t, timeout_pulse, e.p);
    end
    if (e.v) begin
      vectors++;
      assert (gnt_id === e.id) else begin
        miscompares++;
        $error("FAIL %s gnt_id: observed %0d expected %0d", t, gnt_id, e.id);
      end
    end
  endtask

  // Drive req away from the edge, queue the expectation, check after the edge.
  task automatic step(input string t, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] id, input logic v, input logic p);
    @(negedge clk);
    req = r;
    push(t, g, id, v, p);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
    // Rotating order 2,1,0,3,2 with each owner holding two cycles.
    step("rr_g2",   4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_h2",   4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_r2",   4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_g1",   4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_h1",   4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_r1",   4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_g0",   4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_h0",   4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_r0",   4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_g3",   4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_h3",   4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_r3",   4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_g2b",  4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_end",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Fixed priority and release gap.
    step("fp_grant", 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("fp_hold",  4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rel_gap",  4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rel_next", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rel_done", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Watchdog with two contenders: 3 preempted, 0 served, 0 preempted, 3 again.
    step("wd_g3", 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("wd_h3", 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("wd_to3",   4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("wd_g0",    4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("wd_h0", 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("wd_to0",   4'b1001, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("wd_g3b",   4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("wd_rel",   4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("wd_idle",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Lone masked requester is reissued two cycles after preemption.
    step("lone_g", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("lone_h", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("lone_to",    4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("lone_unmsk", 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("lone_reg",   4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("lone_rel",   4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release on the same edge the watchdog would fire: no pulse.
    step("sim_g", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("sim_h", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("sim_rel",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("sim_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // A higher-index request does not preempt the current owner.
    step("nopre_g",   4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("nopre_h",   4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("nopre_rel", 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("nopre_g3",  4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("nopre_end", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a grant is held.
    step("ar_g", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    push("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    compare();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    step("ar_post", 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("ar_end",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
